// File: rtl/lta_argmin_stream_pkg.sv
// ---------------------------------------------------------------------------
// lta_pkg : shared definitions for the least-total-assignment argmin stream.
//   - default parameter values for the top level and its interface
//   - beat-tracking FSM state encoding
//   - clog2_min1() : cluster index width that never collapses to zero bits
// ---------------------------------------------------------------------------
package lta_pkg;

  localparam int DIST_W_DEF       = 32;
  localparam int NUM_CLUSTERS_DEF = 8;
  localparam int PCNT_W_DEF       = 16;

  // IDLE: no beat of the current point accepted yet; ACCUM: point in progress.
  typedef enum logic [0:0] {
    LTA_IDLE  = 1'b0,
    LTA_ACCUM = 1'b1
  } lta_state_e;

  // A single cluster still needs a one-bit index port.
  function automatic int clog2_min1(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/lta_argmin_stream_if.sv
// ---------------------------------------------------------------------------
// lta_argmin_stream_if : stream bundle for the argmin unit.
//   flush                     : drop the partial point in progress
//   dist_valid/ready/data     : distance beats, one per cluster, in index order
//   result_valid/ready        : result handshake towards centroid accumulate
//   cluster_addr/min_dist/tie : winning index, its distance, equal-minimum flag
//   point_cnt                 : number of results delivered (wrapping)
// Modports: slave = the argmin unit, master = the upstream/downstream side.
// ---------------------------------------------------------------------------
interface lta_argmin_stream_if
  import lta_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int IDX_W  = clog2_min1(NUM_CLUSTERS_DEF),
  parameter int PCNT_W = PCNT_W_DEF
);

  logic              flush;
  logic              dist_valid;
  logic              dist_ready;
  logic [DIST_W-1:0] dist_data;
  logic              result_valid;
  logic              result_ready;
  logic [IDX_W-1:0]  cluster_addr;
  logic [DIST_W-1:0] min_dist;
  logic              tie;
  logic [PCNT_W-1:0] point_cnt;

  modport slave (
    input  flush, dist_valid, dist_data, result_ready,
    output dist_ready, result_valid, cluster_addr, min_dist, tie, point_cnt
  );

  modport master (
    output flush, dist_valid, dist_data, result_ready,
    input  dist_ready, result_valid, cluster_addr, min_dist, tie, point_cnt
  );

endinterface

// File: rtl/lta_argmin_stream_min_cmp.sv
// ---------------------------------------------------------------------------
// lta_min_cmp : one step of the running argmin (combinational).
//   best/best_idx/tie_acc : running state before this beat
//   candidate/cand_idx    : incoming distance and its cluster index
//   first                 : candidate is beat 0 and seeds the state
//   next_best/next_idx/next_tie : running state including this beat
// A strictly smaller candidate wins; an equal one keeps the lower (earlier)
// index and only raises the tie flag.
// ---------------------------------------------------------------------------
module lta_min_cmp #(
  parameter int DIST_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic [DIST_W-1:0] best,
  input  logic [IDX_W-1:0]  best_idx,
  input  logic              tie_acc,
  input  logic [DIST_W-1:0] candidate,
  input  logic [IDX_W-1:0]  cand_idx,
  input  logic              first,
  output logic [DIST_W-1:0] next_best,
  output logic [IDX_W-1:0]  next_idx,
  output logic              next_tie
);

  // Strict-less replaces, equal keeps the lower index and flags the tie.
  always_comb begin
    next_best = best;
    next_idx  = best_idx;
    next_tie  = tie_acc;
    if (first) begin
      next_best = candidate;
      next_idx  = '0;
      next_tie  = 1'b0;
    end else if (candidate < best) begin
      next_best = candidate;
      next_idx  = cand_idx;
      next_tie  = 1'b0;
    end else if (candidate == best) begin
      next_best = best;
      next_idx  = best_idx;
      next_tie  = 1'b1;
    end else begin
      next_best = best;
      next_idx  = best_idx;
      next_tie  = tie_acc;
    end
  end

endmodule

// File: rtl/lta_argmin_stream.sv
// ---------------------------------------------------------------------------
// lta_argmin_stream : streaming argmin over NUM_CLUSTERS distances per point.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : lta_argmin_stream_if.slave (distance stream in, result out,
//               flush, delivered-point counter)
// Beats arrive in cluster order; beat k carries the distance to cluster k.
// The result registers load on the last beat and hold until consumed; a new
// last beat may load in the same cycle the old result is taken, so points
// stream with no bubbles.
// ---------------------------------------------------------------------------
module lta_argmin_stream
  import lta_pkg::*;
#(
  parameter int DIST_W       = DIST_W_DEF,
  parameter int NUM_CLUSTERS = NUM_CLUSTERS_DEF,
  parameter int IDX_W        = clog2_min1(NUM_CLUSTERS),
  parameter int PCNT_W       = PCNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  lta_argmin_stream_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLUSTERS - 1);

  lta_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DIST_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic              tie_acc_q, tie_acc_d;
  logic              res_valid_q, res_valid_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [DIST_W-1:0] min_q, min_d;
  logic              tie_q, tie_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  logic              first_s;
  logic              last_s;
  logic              dist_ready_s;
  logic              accept_s;
  logic              res_pop_s;
  logic [DIST_W-1:0] cmp_best_s;
  logic [IDX_W-1:0]  cmp_idx_s;
  logic              cmp_tie_s;

  assign last_s = (cnt_q == LAST_IDX);

  // Only the last beat needs a free result slot; earlier beats just update
  // the running state, so they are gated by flush alone. This lets point N+1
  // fill up while the result of point N waits downstream.
  assign dist_ready_s = ~bus.flush & (~last_s | ~res_valid_q | bus.result_ready);
  assign accept_s     = bus.dist_valid & dist_ready_s;
  assign res_pop_s    = res_valid_q & bus.result_ready;

  lta_min_cmp #(
    .DIST_W (DIST_W),
    .IDX_W  (IDX_W)
  ) u_min_cmp (
    .best      (best_q),
    .best_idx  (best_idx_q),
    .tie_acc   (tie_acc_q),
    .candidate (bus.dist_data),
    .cand_idx  (cnt_q),
    .first     (first_s),
    .next_best (cmp_best_s),
    .next_idx  (cmp_idx_s),
    .next_tie  (cmp_tie_s)
  );

  // FSM next state: leave IDLE on a non-final beat, return on last beat or flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LTA_IDLE: begin
        if (accept_s && !last_s) begin
          state_d = LTA_ACCUM;
        end else begin
          state_d = LTA_IDLE;
        end
      end
      LTA_ACCUM: begin
        if (bus.flush || (accept_s && last_s)) begin
          state_d = LTA_IDLE;
        end else begin
          state_d = LTA_ACCUM;
        end
      end
      default: state_d = LTA_IDLE;
    endcase
  end

  // FSM outputs: in IDLE the incoming beat seeds the running minimum.
  always_comb begin
    first_s = 1'b1;
    case (state_q)
      LTA_IDLE:  first_s = 1'b1;
      LTA_ACCUM: first_s = 1'b0;
      default:   first_s = 1'b1;
    endcase
  end

  // Beat counter and running best; cleared by flush and after the last beat.
  always_comb begin
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    tie_acc_d  = tie_acc_q;
    if (bus.flush) begin
      cnt_d      = '0;
      best_d     = '0;
      best_idx_d = '0;
      tie_acc_d  = 1'b0;
    end else if (accept_s) begin
      if (last_s) begin
        cnt_d      = '0;
        best_d     = '0;
        best_idx_d = '0;
        tie_acc_d  = 1'b0;
      end else begin
        cnt_d      = cnt_q + IDX_W'(1);
        best_d     = cmp_best_s;
        best_idx_d = cmp_idx_s;
        tie_acc_d  = cmp_tie_s;
      end
    end else begin
      cnt_d      = cnt_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      tie_acc_d  = tie_acc_q;
    end
  end

  // Result registers: load on last beat (wins over a same-cycle pop), clear on pop.
  always_comb begin
    res_valid_d = res_valid_q;
    addr_d      = addr_q;
    min_d       = min_q;
    tie_d       = tie_q;
    if (accept_s && last_s) begin
      res_valid_d = 1'b1;
      addr_d      = cmp_idx_s;
      min_d       = cmp_best_s;
      tie_d       = cmp_tie_s;
    end else if (res_pop_s) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Delivered-point counter, wraps silently.
  always_comb begin
    pcnt_d = pcnt_q;
    if (res_pop_s) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LTA_IDLE;
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      tie_acc_q   <= 1'b0;
      res_valid_q <= 1'b0;
      addr_q      <= '0;
      min_q       <= '0;
      tie_q       <= 1'b0;
      pcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      tie_acc_q   <= tie_acc_d;
      res_valid_q <= res_valid_d;
      addr_q      <= addr_d;
      min_q       <= min_d;
      tie_q       <= tie_d;
      pcnt_q      <= pcnt_d;
    end
  end

  assign bus.dist_ready   = dist_ready_s;
  assign bus.result_valid = res_valid_q;
  assign bus.cluster_addr = addr_q;
  assign bus.min_dist     = min_q;
  assign bus.tie          = tie_q;
  assign bus.point_cnt    = pcnt_q;

endmodule

// File: tb/tb_lta_argmin_stream.sv
// ---------------------------------------------------------------------------
// tb_lta_argmin_stream : directed bench for lta_argmin_stream, 4 clusters.
// A reference model collects accepted beats per point and computes the
// argmin from the whole point; a compare process checks every output on
// every falling edge, and the directed sequence adds literal expectations.
// ---------------------------------------------------------------------------
module tb_lta_argmin_stream;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  lta_argmin_stream_if #(.DIST_W(DW), .IDX_W(IW), .PCNT_W(PW)) bus ();

  lta_argmin_stream #(
    .DIST_W       (DW),
    .NUM_CLUSTERS (NC),
    .IDX_W        (IW),
    .PCNT_W       (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] beats [$];
  logic          started   = 1'b0;
  logic          exp_valid = 1'b0;
  logic [IW-1:0] exp_addr  = '0;
  logic [DW-1:0] exp_min   = '0;
  logic          exp_tie   = 1'b0;
  logic [PW-1:0] exp_pcnt  = '0;
  logic          m_rdy;
  logic [DW-1:0] m_min;
  int            m_first;
  int            m_eq;

  function automatic logic model_ready();
    return !bus.flush && ((beats.size() != NC - 1) || !exp_valid || bus.result_ready);
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      beats.delete();
      exp_valid = 1'b0;
      exp_addr  = '0;
      exp_min   = '0;
      exp_tie   = 1'b0;
      exp_pcnt  = '0;
    end else begin
      m_rdy = model_ready();
      if (exp_valid && bus.result_ready) begin
        exp_valid = 1'b0;
        exp_pcnt  = exp_pcnt + 16'd1;
      end
      if (bus.flush) begin
        beats.delete();
      end else if (bus.dist_valid && m_rdy) begin
        beats.push_back(bus.dist_data);
        if (beats.size() == NC) begin
          m_min = beats[0];
          foreach (beats[i]) if (beats[i] < m_min) m_min = beats[i];
          m_first = -1;
          m_eq    = 0;
          foreach (beats[i]) begin
            if (beats[i] == m_min) begin
              if (m_first < 0) m_first = i;
              m_eq++;
            end
          end
          exp_valid = 1'b1;
          exp_addr  = IW'(m_first);
          exp_min   = m_min;
          exp_tie   = (m_eq > 1);
          beats.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("cmp_dist_ready",   64'(bus.dist_ready),   64'(model_ready()));
      check("cmp_result_valid", 64'(bus.result_valid), 64'(exp_valid));
      check("cmp_cluster_addr", 64'(bus.cluster_addr), 64'(exp_addr));
      check("cmp_min_dist",     64'(bus.min_dist),     64'(exp_min));
      check("cmp_tie",          64'(bus.tie),          64'(exp_tie));
      check("cmp_point_cnt",    64'(bus.point_cnt),    64'(exp_pcnt));
    end
  end

  // Present one beat and hold it until the unit takes it (bounded wait).
  task automatic beat(input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    bus.dist_valid = 1'b1;
    bus.dist_data  = d;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = bus.dist_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: got no acceptance expected acceptance of 0x%0h", d);
    end
  endtask

  logic [DW-1:0] tp_vals [12];
  logic [IW-1:0] tp_addr [3];
  logic [DW-1:0] tp_min  [3];
  logic          tp_tie  [3];

  // ---------------- directed stimulus ----------------
  initial begin
    bus.flush        = 1'b0;
    bus.dist_valid   = 1'b0;
    bus.dist_data    = '0;
    bus.result_ready = 1'b1;
    tp_vals = '{32'd3, 32'd1, 32'd2, 32'd4,
                32'd6, 32'd6, 32'd5, 32'd5,
                32'd0, 32'd9, 32'd9, 32'd0};
    tp_addr = '{2'd1, 2'd2, 2'd0};
    tp_min  = '{32'd1, 32'd5, 32'd0};
    tp_tie  = '{1'b0, 1'b1, 1'b1};

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.result_valid), 64'd0);
    check("rst_addr",  64'(bus.cluster_addr), 64'd0);
    check("rst_min",   64'(bus.min_dist),     64'd0);
    check("rst_tie",   64'(bus.tie),          64'd0);
    check("rst_pcnt",  64'(bus.point_cnt),    64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic
    beat(32'd40); beat(32'd12); beat(32'd30);
    check("basic_not_early", 64'(bus.result_valid), 64'd0);
    beat(32'd25);
    bus.dist_valid = 1'b0;
    check("basic_latency", 64'(bus.result_valid), 64'd1);
    check("basic_addr",    64'(bus.cluster_addr), 64'd1);
    check("basic_min",     64'(bus.min_dist),     64'd12);
    check("basic_tie",     64'(bus.tie),          64'd0);
    @(posedge clk); #1;
    check("basic_pcnt",    64'(bus.point_cnt),    64'd1);
    check("basic_popped",  64'(bus.result_valid), 64'd0);

    // ties
    beat(32'd7); beat(32'd9); beat(32'd7); beat(32'd7);
    check("tie1_addr", 64'(bus.cluster_addr), 64'd0);
    check("tie1_min",  64'(bus.min_dist),     64'd7);
    check("tie1_tie",  64'(bus.tie),          64'd1);
    beat(32'd9); beat(32'd3); beat(32'd3); beat(32'd8);
    bus.dist_valid = 1'b0;
    check("tie2_addr", 64'(bus.cluster_addr), 64'd1);
    check("tie2_min",  64'(bus.min_dist),     64'd3);
    check("tie2_tie",  64'(bus.tie),          64'd1);
    @(posedge clk); #1;

    // backpressure
    bus.result_ready = 1'b0;
    beat(32'd5); beat(32'd6); beat(32'd7); beat(32'd2);
    check("bp_valid", 64'(bus.result_valid), 64'd1);
    check("bp_addr",  64'(bus.cluster_addr), 64'd3);
    beat(32'd8); beat(32'd4); beat(32'd6);
    bus.dist_data = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(bus.dist_ready),   64'd0);
      check("bp_hold_addr", 64'(bus.cluster_addr), 64'd3);
      check("bp_hold_min",  64'(bus.min_dist),     64'd2);
    end
    @(posedge clk); #1;
    bus.result_ready = 1'b1;
    #1;
    check("bp_ready_back", 64'(bus.dist_ready), 64'd1);
    @(posedge clk); #1;
    bus.dist_valid = 1'b0;
    check("bp_new_valid", 64'(bus.result_valid), 64'd1);
    check("bp_new_addr",  64'(bus.cluster_addr), 64'd1);
    check("bp_new_min",   64'(bus.min_dist),     64'd4);
    check("bp_pcnt",      64'(bus.point_cnt),    64'd4);
    @(posedge clk); #1;

    // flush
    beat(32'd5); beat(32'd3);
    bus.dist_data = 32'd9;
    bus.flush     = 1'b1;
    #1;
    check("flush_ready_low", 64'(bus.dist_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_no_result", 64'(bus.result_valid), 64'd0);
    beat(32'd9); beat(32'd8); beat(32'd1); beat(32'd6);
    bus.dist_valid = 1'b0;
    check("flush_addr", 64'(bus.cluster_addr), 64'd2);
    check("flush_min",  64'(bus.min_dist),     64'd1);
    @(posedge clk); #1;
    check("flush_pcnt", 64'(bus.point_cnt), 64'd6);

    // reset mid-point
    beat(32'd4); beat(32'd4); beat(32'd4);
    bus.dist_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rmid_valid", 64'(bus.result_valid), 64'd0);
    check("rmid_pcnt",  64'(bus.point_cnt),    64'd0);
    beat(32'hFFFF_FFFF); beat(32'hFFFF_FFFF); beat(32'hFFFF_FFFF); beat(32'hFFFF_FFFE);
    bus.dist_valid = 1'b0;
    check("rmid_addr", 64'(bus.cluster_addr), 64'd3);
    check("rmid_min",  64'(bus.min_dist),     64'h0000_0000_FFFF_FFFE);
    check("rmid_tie",  64'(bus.tie),          64'd0);
    @(posedge clk); #1;

    // throughput: 12 beats back to back
    for (int i = 0; i < 12; i++) begin
      bus.dist_valid = 1'b1;
      bus.dist_data  = tp_vals[i];
      @(negedge clk);
      check("tp_ready", 64'(bus.dist_ready), 64'd1);
      @(posedge clk); #1;
      check("tp_valid_pattern", 64'(bus.result_valid), ((i % 4) == 3) ? 64'd1 : 64'd0);
      if ((i % 4) == 3) begin
        check("tp_addr", 64'(bus.cluster_addr), 64'(tp_addr[i / 4]));
        check("tp_min",  64'(bus.min_dist),     64'(tp_min[i / 4]));
        check("tp_tie",  64'(bus.tie),          64'(tp_tie[i / 4]));
      end
    end
    bus.dist_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("tp_pcnt", 64'(bus.point_cnt), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
